// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit feeding the architectural HI/LO
// registers. Results are computed combinationally at acceptance, held in a
// pending buffer, and committed when the busy down-counter expires so that
// HI/LO only change when Busy drops.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Start,
  input  logic [2:0]  MDOP,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  // Architectural and pending state
  logic [31:0] hi_r, lo_r;
  logic [31:0] pend_hi_r, pend_lo_r;
  logic        pend_we_r;
  logic [3:0]  cnt_r;

  // Next-state values
  logic [31:0] hi_nxt_s, lo_nxt_s;
  logic [31:0] pend_hi_nxt_s, pend_lo_nxt_s;
  logic        pend_we_nxt_s;
  logic [3:0]  cnt_nxt_s;

  // Arithmetic results
  logic [63:0] prod_signed_s, prod_unsigned_s;
  logic [31:0] abs_a_s, abs_b_s;
  logic [31:0] mag_q_s, mag_r_s;
  logic [31:0] sdiv_q_s, sdiv_r_s;
  logic [31:0] udiv_q_s, udiv_r_s;
  logic        b_zero_s;

  // Multiply and divide datapath; signed divide works on magnitudes so the
  // 0x80000000 / -1 overflow falls out naturally as 0x80000000 rem 0.
  always_comb begin
    prod_signed_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_unsigned_s = {32'd0, A} * {32'd0, B};
    b_zero_s        = (B == 32'd0);
    abs_a_s         = A[31] ? (32'd0 - A) : A;
    abs_b_s         = B[31] ? (32'd0 - B) : B;
    if (b_zero_s) begin
      mag_q_s  = 32'd0;
      mag_r_s  = 32'd0;
      udiv_q_s = 32'd0;
      udiv_r_s = 32'd0;
    end else begin
      mag_q_s  = abs_a_s / abs_b_s;
      mag_r_s  = abs_a_s % abs_b_s;
      udiv_q_s = A / B;
      udiv_r_s = A % B;
    end
    sdiv_q_s = (A[31] ^ B[31]) ? (32'd0 - mag_q_s) : mag_q_s;
    sdiv_r_s = A[31] ? (32'd0 - mag_r_s) : mag_r_s;
  end

  // Next-state: count down and commit while busy, otherwise accept a new op
  always_comb begin
    hi_nxt_s      = hi_r;
    lo_nxt_s      = lo_r;
    pend_hi_nxt_s = pend_hi_r;
    pend_lo_nxt_s = pend_lo_r;
    pend_we_nxt_s = pend_we_r;
    cnt_nxt_s     = cnt_r;
    if (cnt_r != 4'd0) begin
      cnt_nxt_s = cnt_r - 4'd1;
      if ((cnt_r == 4'd1) && pend_we_r) begin
        hi_nxt_s = pend_hi_r;
        lo_nxt_s = pend_lo_r;
      end else begin
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
      end
    end else if (Start) begin
      case (MDOP)
        3'd0: begin
          {pend_hi_nxt_s, pend_lo_nxt_s} = prod_signed_s;
          pend_we_nxt_s = 1'b1;
          cnt_nxt_s     = MULT_LOAD;
        end
        3'd1: begin
          {pend_hi_nxt_s, pend_lo_nxt_s} = prod_unsigned_s;
          pend_we_nxt_s = 1'b1;
          cnt_nxt_s     = MULT_LOAD;
        end
        3'd2: begin
          pend_lo_nxt_s = sdiv_q_s;
          pend_hi_nxt_s = sdiv_r_s;
          pend_we_nxt_s = !b_zero_s;
          cnt_nxt_s     = DIV_LOAD;
        end
        3'd3: begin
          pend_lo_nxt_s = udiv_q_s;
          pend_hi_nxt_s = udiv_r_s;
          pend_we_nxt_s = !b_zero_s;
          cnt_nxt_s     = DIV_LOAD;
        end
        3'd4: hi_nxt_s = A;
        3'd5: lo_nxt_s = A;
        default: begin
          hi_nxt_s = hi_r;
          lo_nxt_s = lo_r;
        end
      endcase
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State register with synchronous active-low reset taking full priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_we_r <= 1'b0;
      cnt_r     <= 4'd0;
    end else begin
      hi_r      <= hi_nxt_s;
      lo_r      <= lo_nxt_s;
      pend_hi_r <= pend_hi_nxt_s;
      pend_lo_r <= pend_lo_nxt_s;
      pend_we_r <= pend_we_nxt_s;
      cnt_r     <= cnt_nxt_s;
    end
  end

  assign Busy = (cnt_r != 4'd0);
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed cases plus random operations checked
// against an arithmetic reference model of HI/LO and Busy timing.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        rst_n;
  logic [31:0] A, B;
  logic        Start;
  logic [2:0]  MDOP;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks;
  int errors;

  // Reference model of architectural HI/LO
  logic [31:0] hi_m, lo_m;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Start(Start), .MDOP(MDOP),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Final HI/LO after an operation, from plain integer arithmetic
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      3'd0: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      3'd1: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      3'd2: if (b != 32'd0) begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
      3'd3: if (b != 32'd0) begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endtask

  // Issue one op in an idle cycle and check Busy/HI/LO every cycle until done
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    logic [31:0] nh, nl;
    int n;
    nh = hi_m;
    nl = lo_m;
    model(op, a, b, nh, nl);
    Start = 1'b1; MDOP = op; A = a; B = b;
    tick();
    Start = 1'b0;
    if (op < 3'd4) begin
      n = (op < 3'd2) ? MC : DC;
      for (int i = 0; i < n; i++) begin
        chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
        chk({tag, "_hi_hold"}, HI, hi_m);
        chk({tag, "_lo_hold"}, LO, lo_m);
        A = $urandom;
        B = $urandom;
        if (inject && i == 1) begin
          Start = 1'b1; MDOP = 3'd4; A = 32'hDEAD_BEEF;
        end else begin
          Start = 1'b0;
        end
        tick();
      end
    end
    hi_m = nh;
    lo_m = nl;
    chk({tag, "_busy_done"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_hi"}, HI, hi_m);
    chk({tag, "_lo"}, LO, lo_m);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    checks = 0;
    errors = 0;
    A = 32'd5; B = 32'd5; MDOP = 3'd0; Start = 1'b1; rst_n = 1'b0;

    // Reset for two edges with a mult held on Start
    tick();
    tick();
    Start = 1'b0;
    rst_n = 1'b1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    tick();
    chk("idle_busy", {31'd0, Busy}, 32'd0);
    chk("idle_hi", HI, 32'd0);

    // Directed arithmetic cases
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_neg_hi_const", HI, 32'hFFFF_FFFF);
    chk("mult_neg_lo_const", LO, 32'hFFFF_FFFA);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_hi_const", HI, 32'hFFFF_FFFE);
    chk("multu_lo_const", LO, 32'h0000_0001);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_neg_lo_const", LO, 32'hFFFF_FFFD);
    chk("div_neg_hi_const", HI, 32'hFFFF_FFFF);
    run_op("mthi_11", 3'd4, 32'h11, 32'd0, 1'b0);
    run_op("mtlo_22", 3'd5, 32'h22, 32'd0, 1'b0);
    run_op("divu_zero", 3'd3, 32'd7, 32'd0, 1'b0);
    chk("divu_zero_hi_const", HI, 32'h11);
    chk("divu_zero_lo_const", LO, 32'h22);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_lo_const", LO, 32'h8000_0000);
    chk("div_ovf_hi_const", HI, 32'h0);

    // mthi then mtlo on consecutive cycles
    run_op("mthi_1234", 3'd4, 32'h1234, 32'd0, 1'b0);
    run_op("mtlo_5678", 3'd5, 32'h5678, 32'd0, 1'b0);
    chk("mthi_hi_const", HI, 32'h1234);

    // mthi issued while busy must be dropped
    run_op("mult_inject", 3'd0, 32'd1000, 32'hFFFF_FFF0, 1'b1);
    run_op("div_inject", 3'd2, 32'd12345, 32'd77, 1'b1);

    // No-op MDOP values
    run_op("nop6", 3'd6, 32'hAAAA_AAAA, 32'd1, 1'b0);
    run_op("nop7", 3'd7, 32'h5555_5555, 32'd1, 1'b0);

    // Reset in the middle of a divide discards the pending result
    Start = 1'b1; MDOP = 3'd2; A = 32'd100; B = 32'd7;
    tick();
    Start = 1'b0;
    tick(); tick(); tick();
    chk("middiv_busy", {31'd0, Busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    chk("middiv_rst_hi", HI, 32'd0);
    chk("middiv_rst_lo", LO, 32'd0);
    chk("middiv_rst_busy", {31'd0, Busy}, 32'd0);
    for (int i = 0; i < DC + 2; i++) begin
      tick();
    end
    chk("middiv_nocommit_hi", HI, 32'd0);
    chk("middiv_nocommit_lo", LO, 32'd0);
    run_op("mult_after_rst", 3'd0, 32'd123, 32'd456, 1'b0);

    // Random back-to-back operations
    for (int k = 0; k < 60; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      run_op("rand", rop, ra, rb, ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit for the EX stage, alongside the ALU. It takes the same forwarded operands A and B and produces results into architectural HI/LO registers. It is the producer that mfhi/mflo read from. While an operation is in flight it raises Busy, and the hazard unit stalls any following mult/div/mthi/mtlo/mfhi/mflo in ID.

## Interface
Parameters:
- MULT_CYCLES, default 5: Busy duration for mult/multu (1..15).
- DIV_CYCLES, default 10: Busy duration for div/divu (1..15).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- A, input, 32: rs operand, already forwarded.
- B, input, 32: rt operand, already forwarded.
- Start, input, 1: the EX-stage instruction is an md op; sampled on the rising edge.
- MDOP, input, 3: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are no-ops.
- Busy, output, 1: a mult/div is in flight.
- HI, output, 32: HI register, registered.
- LO, output, 32: LO register, registered.

## Operation
- State: HI, LO, a 4-bit down-counter `cnt`, and 64-bit pending result registers `pend_hi` / `pend_lo` plus a `pend_we` flag.
- Busy = (cnt != 0). It is purely a decode of cnt, with no combinational path from Start.
- Start is accepted only when Busy=0. While Busy=1, Start is ignored entirely, including mthi/mtlo. The pipeline guarantees none arrive; a bench checks they are dropped.
- mult: {pend_hi,pend_lo} = signed A × signed B (64-bit). multu: unsigned product. Both set cnt=MULT_CYCLES and pend_we=1.
- div: pend_lo = signed A / B, truncated toward zero; pend_hi = remainder, whose sign follows A. divu: unsigned quotient/remainder. Both set cnt=DIV_CYCLES.
- Special case, 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0. There is no trap.
- Divide by zero (B==0, div or divu): pend_we=0. Busy still runs the full DIV_CYCLES; HI and LO are left unchanged.
- The operation result is computed combinationally from A and B at the accepting edge and captured into pend_*. Later changes on A and B have no effect.
- mthi: HI<=A on the accepting edge, with no Busy. mtlo: LO<=A likewise. MDOP 6/7 with Start: no state change.
- Commit: on the edge where cnt goes 1→0, if pend_we then HI<=pend_hi and LO<=pend_lo.
- Counter: decrements by 1 per edge while nonzero. No wrap is possible, because loading happens only when cnt==0.

## Timing
- Reset (rst_n=0 at a rising edge): HI=0, LO=0, cnt=0, Busy=0, pend_*=0, pend_we=0. This takes priority over everything, including an in-flight op, whose result is discarded and never committed. Start is ignored on the reset edge.
- Start with mult accepted at edge E0:
  - Busy=1 from after E0 through E0+MULT_CYCLES−1, i.e. for MULT_CYCLES cycles.
  - New HI/LO are visible after edge E0+MULT_CYCLES, in the same cycle Busy reads 0.
  - div follows the same pattern with DIV_CYCLES.
- mthi/mtlo: the new value is visible one cycle after the accepting edge; Busy stays 0.
- Back-to-back: Start may be accepted in the first cycle Busy=0. That is the commit cycle of the previous op, so HI/LO already hold its result. The next op's pend_* overwrite is safe.
- Simultaneous events:
  - Commit edge and new Start cannot coincide, since Busy=1 on the commit edge.
  - mthi on the cycle after commit overwrites the committed HI.
- HI/LO readers (mfhi/mflo) must sample only when Busy=0. Mid-operation HI/LO hold their old values.

## Test plan
- Reset then idle: rst_n=0 for 2 edges → HI=0, LO=0, Busy=0. Start with MDOP=0 during reset → no effect.
- Signed mult, A=0xFFFFFFFE (−2), B=3, Start 1 cycle → Busy high exactly 5 cycles. HI=0xFFFFFFFF and LO=0xFFFFFFFA when Busy falls. HI/LO hold their old values during Busy even if A/B change.
- multu, A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- div cases, each with Busy high 10 cycles:
  - A=−7 (0xFFFFFFF9), B=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - divu A=7, B=0 with prior HI=0x11, LO=0x22 → values unchanged.
  - div 0x80000000 / −1 → LO=0x80000000, HI=0.
- mthi A=0x1234 then mtlo A=0x5678 on consecutive cycles → HI=0x1234 one cycle later and LO=0x5678 the next. Start+mthi issued while Busy → dropped, and the committed result is unaffected.
- Reset mid-div: start div 100/7, assert rst_n=0 at cycle 4 → HI=LO=0 and Busy=0 next cycle; no later commit. A new mult started right after reset completes normally.
